// File: rtl/audio_meter_pkg.sv
// Shared types and constants for the audio level meter blocks.
// Define SECTION_MIN_MAX_SIGNED_EN to treat samples as two's-complement signed.
package audio_meter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef logic [DEFAULT_WIDTH-1:0] sample_t;

`ifdef SECTION_MIN_MAX_SIGNED_EN
    localparam bit SIGNED_COMPARE = 1'b1;
`else
    localparam bit SIGNED_COMPARE = 1'b0;
`endif

endpackage

// File: rtl/min_max_cmp.sv
// Combinational running min/max update; signedness follows SIGNED_COMPARE
// (set by SECTION_MIN_MAX_SIGNED_EN). Ties keep the current value.
module min_max_cmp
    import audio_meter_pkg::*;
#(
    parameter int unsigned width = DEFAULT_WIDTH
) (
    input  logic [width-1:0] min_i,
    input  logic [width-1:0] max_i,
    input  logic [width-1:0] value_i,
    output logic [width-1:0] min_o,
    output logic [width-1:0] max_o
);

    logic below_min;
    logic above_max;

    if (SIGNED_COMPARE) begin : g_signed
        assign below_min = $signed(value_i) < $signed(min_i);
        assign above_max = $signed(value_i) > $signed(max_i);
    end else begin : g_unsigned
        assign below_min = value_i < min_i;
        assign above_max = value_i > max_i;
    end

    assign min_o = below_min ? value_i : min_i;
    assign max_o = above_max ? value_i : max_i;

endmodule

// File: rtl/section_min_max.sv
// Groups an input sample stream into sections of sample_count samples and emits one
// min/max result per section. Signed mode selected by SECTION_MIN_MAX_SIGNED_EN.
module section_min_max
    import audio_meter_pkg::*;
#(
    parameter int unsigned width        = DEFAULT_WIDTH,
    parameter int unsigned sample_count = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [width-1:0] i_value,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [width-1:0] o_min_value,
    output logic [width-1:0] o_max_value
);

    localparam int unsigned CntW = (sample_count > 1) ? $clog2(sample_count) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(sample_count - 1);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [width-1:0] acc_min_q, acc_min_d;
    logic [width-1:0] acc_max_q, acc_max_d;
    logic             o_valid_q, o_valid_d;
    logic [width-1:0] o_min_q, o_min_d;
    logic [width-1:0] o_max_q, o_max_d;

    logic             accept;
    logic [width-1:0] cmp_min, cmp_max;
    logic [width-1:0] upd_min, upd_max;

    min_max_cmp #(
        .width(width)
    ) u_cmp (
        .min_i  (acc_min_q),
        .max_i  (acc_max_q),
        .value_i(i_value),
        .min_o  (cmp_min),
        .max_o  (cmp_max)
    );

    assign i_ready = !o_valid_q || o_ready;
    assign accept  = i_valid && i_ready;

    // The first sample of a section seeds the accumulator instead of comparing.
    assign upd_min = (cnt_q == '0) ? i_value : cmp_min;
    assign upd_max = (cnt_q == '0) ? i_value : cmp_max;

    always_comb begin
        cnt_d     = cnt_q;
        acc_min_d = acc_min_q;
        acc_max_d = acc_max_q;
        o_valid_d = o_valid_q;
        o_min_d   = o_min_q;
        o_max_d   = o_max_q;

        if (o_valid_q && o_ready) begin
            o_valid_d = 1'b0;
        end

        if (accept) begin
            acc_min_d = upd_min;
            acc_max_d = upd_max;
            if (cnt_q == LastCnt) begin
                cnt_d     = '0;
                o_valid_d = 1'b1;
                o_min_d   = upd_min;
                o_max_d   = upd_max;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_min_q <= '0;
            acc_max_q <= '0;
            o_valid_q <= 1'b0;
            o_min_q   <= '0;
            o_max_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_min_q <= acc_min_d;
            acc_max_q <= acc_max_d;
            o_valid_q <= o_valid_d;
            o_min_q   <= o_min_d;
            o_max_q   <= o_max_d;
        end
    end

    assign o_valid     = o_valid_q;
    assign o_min_value = o_min_q;
    assign o_max_value = o_max_q;

endmodule

// File: tb/tb_section_min_max.sv
// Self-checking bench for section_min_max: directed scenarios plus a randomized run
// against a queue-based section model.
module tb_section_min_max;
    import audio_meter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [15:0] i_value = '0;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [15:0] o_min_value;
    logic [15:0] o_max_value;

    logic        i_valid1 = 1'b0;
    logic        i_ready1;
    logic [15:0] i_value1 = '0;
    logic        o_valid1;
    logic        o_ready1 = 1'b1;
    logic [15:0] o_min_value1;
    logic [15:0] o_max_value1;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    section_min_max #(
        .width       (16),
        .sample_count(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .i_value    (i_value),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_min_value(o_min_value),
        .o_max_value(o_max_value)
    );

    section_min_max #(
        .width       (16),
        .sample_count(1)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid1),
        .i_ready    (i_ready1),
        .i_value    (i_value1),
        .o_valid    (o_valid1),
        .o_ready    (o_ready1),
        .o_min_value(o_min_value1),
        .o_max_value(o_max_value1)
    );

    function automatic bit lt16(input logic [15:0] a, input logic [15:0] b);
`ifdef SECTION_MIN_MAX_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_vec++;
        if (o_valid !== 1'b0 || o_min_value !== 16'h0 || o_max_value !== 16'h0)
            begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b min=%h max=%h, want v=0 min=0 max=0",
                     o_valid, o_min_value, o_max_value);
        end
        n_vec++;
        if (i_ready !== 1'b1 || i_ready1 !== 1'b1 || o_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got rdy=%b rdy1=%b v1=%b, want 1 1 0",
                     i_ready, i_ready1, o_valid1);
        end
        step();
        step();
        reset = 1'b0;
        step();
    endtask

`ifndef SECTION_MIN_MAX_SIGNED_EN
    task automatic test_unsigned();
        logic [15:0] samples [12] = '{16'h1111, 16'h9999, 16'h4444, 16'h2222, 16'h6666,
                                      16'h1111, 16'h2222, 16'h5555, 16'h9999, 16'hffff,
                                      16'h9999, 16'h1111};
        logic [15:0] exp_min [4] = '{16'h1111, 16'h1111, 16'h2222, 16'h1111};
        logic [15:0] exp_max [4] = '{16'h9999, 16'h6666, 16'h9999, 16'hffff};
        int pulses = 0;
        o_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            i_valid = 1'b1;
            i_value = samples[i];
            step();
            i_valid = 1'b0;
            if (o_valid === 1'b1) pulses++;
            n_vec++;
            if (o_valid !== (i % 3 == 2)) begin
                n_fail++;
                $display("FAIL unsigned_valid[%0d]: got %b want %b", i, o_valid, (i % 3 == 2));
            end
            if (i % 3 == 2) begin
                n_vec++;
                if (o_min_value !== exp_min[i/3] || o_max_value !== exp_max[i/3]) begin
                    n_fail++;
                    $display("FAIL unsigned_data[%0d]: got %h/%h want %h/%h", i / 3,
                             o_min_value, o_max_value, exp_min[i/3], exp_max[i/3]);
                end
            end
            step();
            if (o_valid === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 4) begin
            n_fail++;
            $display("FAIL unsigned_pulses: got %0d want 4", pulses);
        end
    endtask
`else
    task automatic test_signed();
        logic [15:0] samples [3] = '{16'h1111, 16'h9999, 16'h4444};
        o_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            i_value = samples[i];
            step();
            i_valid = 1'b0;
            step();
        end
        // Result was presented one cycle before the idle step and consumed there.
        n_vec++;
        if (o_min_value !== 16'h9999 || o_max_value !== 16'h4444 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL signed_section: got %h/%h v=%b want 9999/4444 v=0",
                     o_min_value, o_max_value, o_valid);
        end
    endtask
`endif

    task automatic feed(input logic [15:0] v);
        i_valid = 1'b1;
        i_value = v;
        step();
        i_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] m0, m1;
        o_ready = 1'b1;
        feed(16'h1111);
        step();
        feed(16'h9999);
        step();
        o_ready = 1'b0;
        feed(16'h1111 ^ 16'h5555);
        m0 = lt16(16'h4444, 16'h1111) ? 16'h4444 : 16'h1111;
        m0 = lt16(16'h9999, m0) ? 16'h9999 : m0;
        m1 = lt16(16'h1111, 16'h9999) ? 16'h9999 : 16'h1111;
        m1 = lt16(m1, 16'h4444) ? 16'h4444 : m1;
        i_valid = 1'b1;
        i_value = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i_ready !== 1'b0 || o_valid !== 1'b1 || o_min_value !== m0
                || o_max_value !== m1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b %h/%h want rdy=0 v=1 %h/%h", i,
                         i_ready, o_valid, o_min_value, o_max_value, m0, m1);
            end
            step();
        end
        o_ready = 1'b1;
        #1;
        n_vec++;
        if (i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 1", i_ready);
        end
        step();
        i_valid = 1'b0;
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_consumed: got v=%b want 0", o_valid);
        end
        step();
        feed(16'h3333);
        step();
        feed(16'h5555);
        m0 = lt16(16'h3333, 16'h2222) ? 16'h3333 : 16'h2222;
        m0 = lt16(16'h5555, m0) ? 16'h5555 : m0;
        m1 = lt16(16'h2222, 16'h3333) ? 16'h3333 : 16'h2222;
        m1 = lt16(m1, 16'h5555) ? 16'h5555 : m1;
        n_vec++;
        if (o_valid !== 1'b1 || o_min_value !== m0 || o_max_value !== m1) begin
            n_fail++;
            $display("FAIL bp_next_section: got v=%b %h/%h want v=1 %h/%h",
                     o_valid, o_min_value, o_max_value, m0, m1);
        end
        step();
    endtask

    task automatic test_reset_mid_section();
        o_ready = 1'b1;
        feed(16'h0005);
        step();
        feed(16'h0001);
        reset = 1'b1;
        #1;
        n_vec++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_during: got v=%b rdy=%b want v=0 rdy=1", o_valid, i_ready);
        end
        step();
        reset = 1'b0;
        step();
        feed(16'h0007);
        step();
        feed(16'h0008);
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_partial: got v=%b want 0", o_valid);
        end
        step();
        feed(16'h0009);
        n_vec++;
        if (o_valid !== 1'b1 || o_min_value !== 16'h0007 || o_max_value !== 16'h0009) begin
            n_fail++;
            $display("FAIL midreset_result: got v=%b %h/%h want v=1 0007/0009",
                     o_valid, o_min_value, o_max_value);
        end
        step();
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_single: got v=%b want 0", o_valid);
        end
    endtask

    task automatic test_count_one();
        logic [15:0] vals [2] = '{16'h0003, 16'h0002};
        i_valid1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            i_value1 = vals[i];
            step();
            n_vec++;
            if (o_valid1 !== 1'b1 || o_min_value1 !== vals[i] || o_max_value1 !== vals[i])
                begin
                n_fail++;
                $display("FAIL count1[%0d]: got v=%b %h/%h want v=1 %h/%h", i, o_valid1,
                         o_min_value1, o_max_value1, vals[i], vals[i]);
            end
        end
        i_valid1 = 1'b0;
        step();
        n_vec++;
        if (o_valid1 !== 1'b0 || o_min_value1 !== 16'h0002) begin
            n_fail++;
            $display("FAIL count1_idle: got v=%b min=%h want v=0 min=0002",
                     o_valid1, o_min_value1);
        end
    endtask

    task automatic test_random();
        logic [15:0] corners [4] = '{16'h0000, 16'hffff, 16'h8000, 16'h7fff};
        logic [15:0] sec [$];
        logic [15:0] exp_min_q [$];
        logic [15:0] exp_max_q [$];
        logic [15:0] mn, mx;
        bit acc, fire;
        for (int cyc = 0; cyc < 600; cyc++) begin
            i_valid = ($urandom_range(0, 2) != 0);
            i_value = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)]
                                                  : 16'($urandom);
            o_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n_vec++;
            if (o_valid !== (exp_min_q.size() != 0)) begin
                n_fail++;
                $display("FAIL rand_valid@%0d: got %b want %b", cyc, o_valid,
                         exp_min_q.size() != 0);
            end
            if (exp_min_q.size() != 0) begin
                n_vec++;
                if (o_min_value !== exp_min_q[0] || o_max_value !== exp_max_q[0]) begin
                    n_fail++;
                    $display("FAIL rand_data@%0d: got %h/%h want %h/%h", cyc, o_min_value,
                             o_max_value, exp_min_q[0], exp_max_q[0]);
                end
            end
            n_vec++;
            if (i_ready !== (exp_min_q.size() == 0 || o_ready)) begin
                n_fail++;
                $display("FAIL rand_ready@%0d: got %b want %b", cyc, i_ready,
                         exp_min_q.size() == 0 || o_ready);
            end
            acc  = i_valid && (exp_min_q.size() == 0 || o_ready);
            fire = (exp_min_q.size() != 0) && o_ready;
            step();
            if (fire) begin
                void'(exp_min_q.pop_front());
                void'(exp_max_q.pop_front());
            end
            if (acc) begin
                sec.push_back(i_value);
                if (sec.size() == 3) begin
                    mn = sec[0];
                    mx = sec[0];
                    foreach (sec[k]) begin
                        if (lt16(sec[k], mn)) mn = sec[k];
                        if (lt16(mx, sec[k])) mx = sec[k];
                    end
                    exp_min_q.push_back(mn);
                    exp_max_q.push_back(mx);
                    sec.delete();
                end
            end
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
    endtask

    initial begin
        test_reset();
`ifndef SECTION_MIN_MAX_SIGNED_EN
        test_unsigned();
`else
        test_signed();
`endif
        test_backpressure();
        test_reset_mid_section();
        test_count_one();
        test_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
